// File: rtl/segment_capture.sv
// segment_capture
//   Receive-side checker for the two-module multiplexed 7-segment display. Samples both
//   segment buses, waits for each CAT phase to settle, decodes the patterns back to BCD
//   and reassembles the 4-digit value shown on the display.
// Ports
//   CLK         in   1   system clock (faster than the display mux rate)
//   RST         in   1   asynchronous active-high reset
//   Segment7_0  in   8   right module: [7:1]=a..g, [0]=CAT (1 tens, 0 ones)
//   Segment7_1  in   8   left module:  [7:1]=a..g, [0]=CAT (1 thousands, 0 hundreds)
//   Result      out  16  {thousands,hundreds,tens,ones} of the last complete frame
//   Valid       out  1   one-cycle pulse when Result/Error update
//   Error       out  1   last frame held at least one undecodable pattern
//   Stalled     out  1   CAT has not toggled for TIMEOUT_CYCLES
module segment_capture #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 17
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  Segment7_0,
    input  logic [7:0]  Segment7_1,
    output logic [15:0] Result,
    output logic        Valid,
    output logic        Error,
    output logic        Stalled
);
    localparam int unsigned BUS_W  = 16;
    localparam int unsigned SLOT_W = 10;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT   = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    // Pattern {a..g} -> {invalid, digit}; anything unrecognised reads as 4'hF.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h7E:   r = {1'b0, 4'd0};
            7'h30:   r = {1'b0, 4'd1};
            7'h6D:   r = {1'b0, 4'd2};
            7'h79:   r = {1'b0, 4'd3};
            7'h33:   r = {1'b0, 4'd4};
            7'h5B:   r = {1'b0, 4'd5};
            7'h5F:   r = {1'b0, 4'd6};
            7'h70:   r = {1'b0, 4'd7};
            7'h7F:   r = {1'b0, 4'd8};
            7'h7B:   r = {1'b0, 4'd9};
            default: r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    logic [BUS_W-1:0]  sync1_q, sync1_d;
    logic [BUS_W-1:0]  sync2_q, sync2_d;
    logic [1:0]        fill_q, fill_d;
    logic [BUS_W-1:0]  prev_q, prev_d;
    logic              ref_cat_q, ref_cat_d;
    logic              ref_vld_q, ref_vld_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic              have_hi_q, have_hi_d;
    logic [SLOT_W-1:0] hi_q, hi_d;
    logic [SLOT_W-1:0] lo_q, lo_d;
    logic              pend_q, pend_d;
    logic [15:0]       result_q, result_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic              stalled_q, stalled_d;

    logic              cat_ok;
    logic              cat;
    logic              cat_edge;
    logic              same;
    logic              tmo_hit;
    logic [SLOT_W-1:0] slot;

    // fill_q keeps the cleared sync flops from being mistaken for a real CAT level.
    assign cat_ok   = fill_q[1] && (sync2_q[0] == sync2_q[8]);
    assign cat      = sync2_q[0];
    assign cat_edge = cat_ok && ref_vld_q && (cat != ref_cat_q);
    assign same     = cat_ok && (sync2_q == prev_q);
    // slot = {inv_l, digit_l, inv_r, digit_r}
    assign slot     = {decode_seg(sync2_q[15:9]), decode_seg(sync2_q[7:1])};

    // Next-state, counters and output staging.
    always_comb begin
        sync1_d   = {Segment7_1, Segment7_0};
        sync2_d   = sync1_q;
        fill_d    = {fill_q[0], 1'b1};
        prev_d    = sync2_q;
        ref_cat_d = ref_cat_q;
        ref_vld_d = ref_vld_q;
        state_d   = state_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        have_hi_d = have_hi_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = 1'b0;
        result_d  = result_q;
        valid_d   = 1'b0;
        error_d   = error_q;
        stalled_d = stalled_q;
        tmo_hit   = 1'b0;

        if (cat_ok) begin
            ref_cat_d = cat;
            ref_vld_d = 1'b1;
        end

        // Publish the frame the cycle after the lo phase latched.
        if (pend_q) begin
            result_d = {hi_q[8:5], lo_q[8:5], hi_q[3:0], lo_q[3:0]};
            error_d  = hi_q[9] | hi_q[4] | lo_q[9] | lo_q[4];
            valid_d  = 1'b1;
        end

        // Edge watchdog; an edge always beats the timeout.
        if (cat_edge) begin
            tmo_d     = '0;
            stalled_d = 1'b0;
        end else if (tmo_q != TMO_LIMIT) begin
            tmo_d = tmo_q + CNT_W'(1);
            if (tmo_q == TMO_LAST) begin
                tmo_hit = 1'b1;
            end
        end

        case (state_q)
            S_SYNC: begin
                settle_d = '0;
                if (cat_edge) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cat_edge) begin
                    // Phase ended before it settled: a lost hi phase breaks the frame.
                    settle_d = '0;
                    if (ref_cat_q) begin
                        have_hi_d = 1'b0;
                    end
                end else if (same) begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_d = '0;
                        state_d  = S_HOLD;
                        if (cat) begin
                            hi_d      = slot;
                            have_hi_d = 1'b1;
                        end else begin
                            lo_d      = slot;
                            have_hi_d = 1'b0;
                            pend_d    = have_hi_q;
                        end
                    end else begin
                        settle_d = settle_q + CNT_W'(1);
                    end
                end else begin
                    settle_d = '0;
                end
            end
            S_HOLD: begin
                settle_d = '0;
                if (cat_edge) begin
                    state_d = S_SETTLE;
                end
            end
            default: begin
                state_d  = S_SYNC;
                settle_d = '0;
            end
        endcase

        if (tmo_hit) begin
            stalled_d = 1'b1;
            have_hi_d = 1'b0;
            pend_d    = 1'b0;
            settle_d  = '0;
            state_d   = S_SYNC;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            fill_q    <= '0;
            prev_q    <= '0;
            ref_cat_q <= 1'b0;
            ref_vld_q <= 1'b0;
            state_q   <= S_SYNC;
            settle_q  <= '0;
            tmo_q     <= '0;
            have_hi_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            fill_q    <= fill_d;
            prev_q    <= prev_d;
            ref_cat_q <= ref_cat_d;
            ref_vld_q <= ref_vld_d;
            state_q   <= state_d;
            settle_q  <= settle_d;
            tmo_q     <= tmo_d;
            have_hi_q <= have_hi_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            stalled_q <= stalled_d;
        end
    end

    assign Result  = result_q;
    assign Valid   = valid_q;
    assign Error   = error_q;
    assign Stalled = stalled_q;

endmodule

// File: tb/tb_segment_capture.sv
// tb_segment_capture
//   Self-checking bench for segment_capture: table of whole frames, hand sequences for
//   glitches, latency, timeout, reset and CAT disagreement, then random phases against a
//   phase-level reference model.
module tb_segment_capture;
    localparam int unsigned STABLE = 4;
    localparam int unsigned TMO    = 200;
    localparam int unsigned NPH    = 120;

    localparam logic [6:0] PAT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  seg0;
    logic [7:0]  seg1;
    logic [15:0] Result;
    logic        Valid;
    logic        Error;
    logic        Stalled;

    segment_capture #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (17)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Segment7_0(seg0),
        .Segment7_1(seg1),
        .Result    (Result),
        .Valid     (Valid),
        .Error     (Error),
        .Stalled   (Stalled)
    );

    always #5 CLK = ~CLK;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    int unsigned valid_cyc = 0;
    logic [16:0] obs_q[$];
    logic [16:0] exp_q[$];
    logic [15:0] last_res = 16'h0;
    logic        last_err = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Collect every Valid pulse; outside pulses Result/Error must not move.
    always @(negedge CLK) begin
        if (RST) begin
            last_res = 16'h0;
            last_err = 1'b0;
        end else begin
            if (Valid) begin
                obs_q.push_back({Error, Result});
                valid_cyc = cyc;
            end else begin
                chk("hold", {15'h0, Error, Result}, {15'h0, last_err, last_res});
            end
            last_res = Result;
            last_err = Error;
        end
    end

    function automatic logic [6:0] enc(input logic [3:0] d);
        if (d < 4'd10) return PAT[int'(d)];
        else if (d == 4'hE) return 7'h01;
        else return 7'h00;
    endfunction

    function automatic logic [3:0] dec(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (PAT[i] == p) return 4'(i);
        end
        return 4'hF;
    endfunction

    task automatic drive(input logic c0, input logic c1, input logic [6:0] pl,
                         input logic [6:0] pr, input int n);
        seg1 = {pl, c1};
        seg0 = {pr, c0};
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic frame(input logic [15:0] v, input int hl, input int ll);
        drive(1'b1, 1'b1, enc(v[15:12]), enc(v[7:4]), hl);
        drive(1'b0, 1'b0, enc(v[11:8]),  enc(v[3:0]), ll);
    endtask

    task automatic expect_one(input string name, input logic [15:0] res, input logic err);
        logic [16:0] o;
        chk({name, "_cnt"}, obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            chk({name, "_res"}, {16'h0, o[15:0]}, {16'h0, res});
            chk({name, "_err"}, {31'h0, o[16]}, {31'h0, err});
        end
        obs_q.delete();
    endtask

    task automatic expect_none(input string name);
        chk(name, obs_q.size(), 0);
        obs_q.delete();
    endtask

    typedef struct {
        logic [15:0] din;
        logic [15:0] res;
        logic        err;
    } vec_t;

    vec_t tbl[9];

    initial begin : main
        logic        c;
        logic [6:0]  pl, pr, gl, gr, ll, lr;
        logic [13:0] m;
        int          a, g, b, r;
        logic        found;
        logic        have_hi;
        logic [3:0]  hl, hr;
        int unsigned drive_cyc;

        // digit E drives an undecodable pattern, F drives blank
        tbl[0] = '{16'h1234, 16'h1234, 1'b0};
        tbl[1] = '{16'h9870, 16'h9870, 1'b0};
        tbl[2] = '{16'h1F34, 16'h1F34, 1'b1};
        tbl[3] = '{16'h1234, 16'h1234, 1'b0};
        tbl[4] = '{16'hE0E0, 16'hF0F0, 1'b1};
        tbl[5] = '{16'h0000, 16'h0000, 1'b0};
        tbl[6] = '{16'h34F9, 16'h34F9, 1'b1};
        tbl[7] = '{16'h5678, 16'h5678, 1'b0};
        tbl[8] = '{16'h9999, 16'h9999, 1'b0};

        RST  = 1'b1;
        seg0 = 8'h00;
        seg1 = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_result",  {16'h0, Result}, 32'h0);
        chk("rst_valid",   {31'h0, Valid}, 32'h0);
        chk("rst_error",   {31'h0, Error}, 32'h0);
        chk("rst_stalled", {31'h0, Stalled}, 32'h0);
        RST = 1'b0;

        // Phase in progress at reset release is discarded.
        drive(1'b0, 1'b0, enc(4'd2), enc(4'd4), 20);
        expect_none("prime");

        for (int i = 0; i < 9; i++) begin
            frame(tbl[i].din, 20, 20);
            expect_one($sformatf("tbl%0d", i), tbl[i].res, tbl[i].err);
        end

        // New value arrives before the hi phase settles, then lo-phase latency.
        drive(1'b1, 1'b1, enc(4'd1), enc(4'd3), 2);
        drive(1'b1, 1'b1, enc(4'd9), enc(4'd7), 18);
        drive_cyc = cyc;
        drive(1'b0, 1'b0, enc(4'd8), enc(4'd0), 20);
        expect_one("midhi", 16'h9870, 1'b0);
        chk("latency", valid_cyc - drive_cyc - 1, 2 + STABLE + 1);

        // Short glitch inside the hi phase does not disturb the captured value.
        drive(1'b1, 1'b1, enc(4'd1), enc(4'd3), 2);
        drive(1'b1, 1'b1, enc(4'd1) ^ 7'h55, enc(4'd3), STABLE - 1);
        drive(1'b1, 1'b1, enc(4'd1), enc(4'd3), 15);
        drive(1'b0, 1'b0, enc(4'd2), enc(4'd4), 20);
        expect_one("glitch", 16'h1234, 1'b0);

        // Hi latched, lo too short, hi too short: the frame must be dropped.
        drive(1'b1, 1'b1, enc(4'd5), enc(4'd7), 20);
        drive(1'b0, 1'b0, enc(4'd6), enc(4'd8), STABLE - 2);
        drive(1'b1, 1'b1, enc(4'd5), enc(4'd7), STABLE - 2);
        drive(1'b0, 1'b0, enc(4'd6), enc(4'd8), 20);
        expect_none("short");
        frame(16'h5678, 20, 20);
        expect_one("after_short", 16'h5678, 1'b0);

        // CAT frozen high long enough to trip the watchdog.
        drive(1'b1, 1'b1, enc(4'd1), enc(4'd3), 150);
        chk("stall_early", {31'h0, Stalled}, 32'h0);
        drive(1'b1, 1'b1, enc(4'd1), enc(4'd3), 60);
        chk("stall_set", {31'h0, Stalled}, 32'h1);
        chk("stall_hold", {16'h0, Result}, {16'h0, 16'h5678});
        drive(1'b0, 1'b0, enc(4'd2), enc(4'd4), 5);
        chk("stall_clear", {31'h0, Stalled}, 32'h0);
        drive(1'b0, 1'b0, enc(4'd2), enc(4'd4), 15);
        expect_none("stall_lo_only");
        frame(16'h1234, 20, 20);
        expect_one("stall_resume", 16'h1234, 1'b0);

        // Reset in the middle of the lo phase of 5678.
        drive(1'b1, 1'b1, enc(4'd5), enc(4'd7), 20);
        drive(1'b0, 1'b0, enc(4'd6), enc(4'd8), 3);
        obs_q.delete();
        RST = 1'b1;
        #1;
        chk("rst_mid_result", {16'h0, Result}, 32'h0);
        chk("rst_mid_valid",  {31'h0, Valid}, 32'h0);
        chk("rst_mid_error",  {31'h0, Error}, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(1'b0, 1'b0, enc(4'd6), enc(4'd8), 17);
        expect_none("rst_partial");
        frame(16'h5678, 20, 20);
        expect_one("rst_resume", 16'h5678, 1'b0);

        // Modules disagree on CAT: nothing may latch until they agree again.
        drive(1'b1, 1'b1, enc(4'd4), enc(4'd2), 20);
        drive(1'b0, 1'b1, enc(4'd3), enc(4'd1), 30);
        expect_none("cat_mismatch");
        drive(1'b0, 1'b0, enc(4'd3), enc(4'd1), 20);
        expect_one("cat_agree", 16'h4321, 1'b0);

        // Random phases against a phase-level model.
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(1'b0, 1'b0, enc(4'd0), enc(4'd0), 10);
        obs_q.delete();
        exp_q.delete();
        have_hi = 1'b0;
        hl = 4'h0;
        hr = 4'h0;
        for (int p = 0; p < NPH; p++) begin
            c = (p % 2 == 0);
            r = $urandom_range(0, 15);
            pl = (r < 10) ? PAT[r] : ((r == 10) ? 7'h00 : 7'($urandom));
            r = $urandom_range(0, 15);
            pr = (r < 10) ? PAT[r] : ((r == 10) ? 7'h00 : 7'($urandom));
            m  = 14'($urandom_range(1, 16383));
            gl = pl ^ m[13:7];
            gr = pr ^ m[6:0];
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, 7);
                g = $urandom_range(1, 6);
                b = $urandom_range(0, 7);
            end else begin
                a = $urandom_range(2, 14);
                g = 0;
                b = 0;
            end
            if (a > 0) drive(c, c, pl, pr, a);
            if (g > 0) drive(c, c, gl, gr, g);
            if (b > 0) drive(c, c, pl, pr, b);

            // First run of at least STABLE+1 identical samples is what gets captured.
            found = 1'b1;
            if (a >= STABLE + 1) begin
                ll = pl; lr = pr;
            end else if (g >= STABLE + 1) begin
                ll = gl; lr = gr;
            end else if (b >= STABLE + 1) begin
                ll = pl; lr = pr;
            end else begin
                found = 1'b0;
                ll = 7'h0; lr = 7'h0;
            end
            if (found) begin
                if (c) begin
                    hl = dec(ll);
                    hr = dec(lr);
                    have_hi = 1'b1;
                end else begin
                    if (have_hi) begin
                        exp_q.push_back({(hl == 4'hF) || (hr == 4'hF) ||
                                         (dec(ll) == 4'hF) || (dec(lr) == 4'hF),
                                         hl, dec(ll), hr, dec(lr)});
                    end
                    have_hi = 1'b0;
                end
            end else if (c) begin
                have_hi = 1'b0;
            end
        end
        // Trailing hi phase lets the last lo result drain; a hi phase never reports.
        drive(1'b1, 1'b1, enc(4'd1), enc(4'd1), 12);

        chk("rand_cnt", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("rand%0d", i), {15'h0, obs_q[i]}, {15'h0, exp_q[i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
